// File: rtl/pps_period_monitor.sv
// pps_period_monitor: PPS period/lock/error monitor; define PPS_TRIG_COUNT_EN to count i_trig pulses per PPS window
module pps_period_monitor #(
  parameter int PERIOD_NOM = 100000000,
  parameter int PERIOD_TOL = 1000,
  parameter int LOCK_NUM   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pps,
  input  logic        i_trig,
  input  logic        i_clr_err,
  output logic        o_pps_pulse,
  output logic [31:0] o_period,
  output logic        o_period_vld,
  output logic [15:0] o_trig_count,
  output logic        o_locked,
  output logic [1:0]  o_err,
  output logic [3:0]  o_cstate
);
  localparam logic [31:0] LO = 32'(PERIOD_NOM - PERIOD_TOL);
  localparam logic [31:0] HI = 32'(PERIOD_NOM + PERIOD_TOL);
  localparam int GW = $clog2(LOCK_NUM + 1);
  localparam logic [3:0] IDLE = 4'd0, MEASURE = 4'd1, LOCKED = 4'd2, LOST = 4'd3;
  logic [2:0] sync;
  logic [31:0] cnt;
  logic [GW-1:0] good_cnt, good_nxt;
  logic [3:0] state, state_nxt;
  logic [1:0] err_set;
  logic edge_det, tracking, report, is_short, is_long, valid, timeout, good_hit;
  assign edge_det = sync[1] & ~sync[2];
  assign tracking = state == MEASURE || state == LOCKED;
  assign report = edge_det & tracking;
  assign is_short = cnt < LO;
  assign is_long = cnt > HI;
  assign valid = ~is_short & ~is_long;
  assign timeout = tracking & ~edge_det & is_long;
  assign good_hit = good_cnt + GW'(1) == GW'(LOCK_NUM);
  assign o_cstate = state;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      o_locked <= 1'b0;
    end else begin
      state <= state_nxt;
      o_locked <= state_nxt == LOCKED;
    end
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = edge_det ? MEASURE : IDLE;
      MEASURE: state_nxt = timeout ? LOST : (report && valid && good_hit) ? LOCKED : MEASURE;
      LOCKED:  state_nxt = timeout ? LOST : (report && !valid) ? MEASURE : LOCKED;
      LOST:    state_nxt = edge_det ? MEASURE : LOST;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    err_set = {timeout | (report & is_long), report & is_short};
    good_nxt = !report ? (state == LOST ? '0 : good_cnt)
             : !valid ? '0
             : state == MEASURE ? good_cnt + GW'(1) : good_cnt;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync <= '0;
      cnt <= '0;
      good_cnt <= '0;
      o_pps_pulse <= 1'b0;
      o_period <= '0;
      o_period_vld <= 1'b0;
      o_err <= '0;
    end else begin
      sync <= {sync[1:0], i_pps};
      cnt <= edge_det ? 32'd1 : cnt + {31'd0, ~&cnt};
      good_cnt <= good_nxt;
      o_pps_pulse <= edge_det;
      o_period <= report ? cnt : o_period;
      o_period_vld <= report;
      o_err <= (o_err & {2{~i_clr_err}}) | err_set;
    end
`ifdef PPS_TRIG_COUNT_EN
  logic [15:0] tcnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      tcnt <= '0;
      o_trig_count <= '0;
    end else if (edge_det) begin
      o_trig_count <= tcnt;
      tcnt <= {15'd0, i_trig};
    end else if (i_trig && tcnt != '1) begin
      tcnt <= tcnt + 16'd1;
    end
`else
  logic unused_trig;
  assign unused_trig = i_trig;
  assign o_trig_count = '0;
`endif
endmodule

// File: tb/tb_pps_period_monitor.sv
// tb_pps_period_monitor: randomized PPS/trigger stimulus with a scoreboard fed by a spec-level reference model
module tb_pps_period_monitor;
  localparam int NOM = 1000, TOL = 10, LOCKN = 3;
  logic i_clk = 0, i_rst_n = 0, i_pps = 0, i_trig = 0, i_clr_err = 0;
  logic o_pps_pulse, o_period_vld, o_locked;
  logic [31:0] o_period;
  logic [15:0] o_trig_count;
  logic [1:0] o_err;
  logic [3:0] o_cstate;

  pps_period_monitor #(.PERIOD_NOM(NOM), .PERIOD_TOL(TOL), .LOCK_NUM(LOCKN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pps(i_pps), .i_trig(i_trig), .i_clr_err(i_clr_err),
    .o_pps_pulse(o_pps_pulse), .o_period(o_period), .o_period_vld(o_period_vld),
    .o_trig_count(o_trig_count), .o_locked(o_locked), .o_err(o_err), .o_cstate(o_cstate)
  );

  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { bit vld; int period; int trig; int st; bit lk; bit [1:0] err; } edge_t;
  typedef struct { int at; bit [1:0] err; } lost_t;
  edge_t exp_edge[$];
  lost_t exp_lost[$];
  int tests = 0, fails = 0;

  int m_state = 0, m_good = 0, m_last_e = 0, m_period = 0;
  bit [1:0] m_err = 0;
  int trig_q[$];
  int pps_rise = -100, last_rise = 0;
  bit rnd_clr = 0, force_clr = 0, clr_edge = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: decisions are made per PPS edge from the elapsed time since the previous edge.
  task automatic model(input int c);
    bit e;
    bit [1:0] set;
    edge_t r;
    e = (c == pps_rise + 2);
    set = 2'b00;
    r.vld = 0;
    r.trig = 0;
    if (e) begin
      r.trig = trig_q.size();
      trig_q.delete();
      if (m_state == 0 || m_state == 3) begin
        m_state = 1;
        m_good = 0;
      end else begin
        m_period = c - m_last_e;
        r.vld = 1;
        set = {m_period > NOM + TOL, m_period < NOM - TOL};
        if (set != 0) begin
          m_good = 0;
          m_state = 1;
        end else if (m_state == 1) begin
          m_good = m_good + 1;
          if (m_good == LOCKN) m_state = 2;
        end
      end
      m_last_e = c;
    end else if ((m_state == 1 || m_state == 2) && c - m_last_e == NOM + TOL + 1) begin
      m_state = 3;
      set = 2'b10;
    end
    m_err = (i_clr_err ? 2'b00 : m_err) | set;
    if (e) begin
      r.period = m_period;
      r.st = m_state;
      r.lk = (m_state == 2);
      r.err = m_err;
`ifndef PPS_TRIG_COUNT_EN
      r.trig = 0;
`endif
      exp_edge.push_back(r);
    end else if (set != 0) begin
      exp_lost.push_back('{at: c + 1, err: m_err});
    end
    if (i_trig) trig_q.push_back(c);
  endtask

  task automatic step();
    int c;
    @(posedge i_clk);
    #1;
    c = cyc;
    i_pps = (c >= pps_rise && c < pps_rise + 5);
    i_trig = ($urandom_range(0, 9) == 0) || (c == pps_rise + 2 && $urandom_range(0, 1) == 1);
    i_clr_err = force_clr || (c == pps_rise + 2 && clr_edge) || (rnd_clr && $urandom_range(0, 399) == 0);
    force_clr = 0;
    model(c);
  endtask

  task automatic pulse(input int gap, input bit clr = 0);
    pps_rise = last_rise + gap;
    clr_edge = clr;
    while (cyc < pps_rise + 6) step();
    last_rise = pps_rise;
    clr_edge = 0;
  endtask

  task automatic do_reset(input int hold);
    @(posedge i_clk);
    #1;
    i_rst_n = 0;
    i_pps = 0;
    i_trig = 0;
    i_clr_err = 0;
    repeat (hold) @(posedge i_clk);
    #1;
    check("rst_pps_pulse", o_pps_pulse, 0);
    check("rst_period", o_period, 0);
    check("rst_period_vld", o_period_vld, 0);
    check("rst_trig_count", o_trig_count, 0);
    check("rst_locked", o_locked, 0);
    check("rst_err", o_err, 0);
    check("rst_cstate", o_cstate, 0);
    i_rst_n = 1;
    m_state = 0;
    m_good = 0;
    m_err = 0;
    m_period = 0;
    trig_q.delete();
    pps_rise = -100;
    last_rise = cyc;
  endtask

  initial begin
    logic [3:0] prev_cstate;
    edge_t r;
    lost_t l;
    prev_cstate = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_period_vld && !o_pps_pulse) begin
          tests++;
          fails++;
          $display("FAIL vld_without_pulse: o_period_vld=1 with o_pps_pulse=0 (cycle %0d)", cyc);
        end
        if (o_pps_pulse) begin
          if (exp_edge.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pps_pulse: got unexpected strobe, expected none (cycle %0d)", cyc);
          end else begin
            r = exp_edge.pop_front();
            check("period_vld", o_period_vld, r.vld);
            check("period", o_period, r.period);
            check("trig_count", o_trig_count, r.trig);
            check("cstate", o_cstate, r.st);
            check("locked", o_locked, r.lk);
            check("err", o_err, r.err);
          end
        end
        if (o_cstate == 3 && prev_cstate != 3) begin
          if (exp_lost.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL lost_entry: got unexpected LOST, expected none (cycle %0d)", cyc);
          end else begin
            l = exp_lost.pop_front();
            check("lost_cycle", cyc, l.at);
            check("lost_locked", o_locked, 0);
            check("lost_err", o_err, l.err);
          end
        end
      end
      prev_cstate = o_cstate;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int gap, sel;
    do_reset(3);
    repeat (5) pulse(1000);
    pulse(990);
    pulse(1010);
    pulse(989);
    repeat (3) pulse(1000);
    pulse(1011);
    repeat (4) pulse(1000);
    pulse(985, 1);
    repeat (20) step();
    force_clr = 1;
    step();
    pulse(1000);
    repeat (3) pulse(1000);
    pulse(1500);
    repeat (4) pulse(1000);
    rnd_clr = 1;
    repeat (24) begin
      sel = $urandom_range(0, 3);
      gap = sel == 0 ? $urandom_range(1012, 1400) : sel == 1 ? $urandom_range(985, 1015) : $urandom_range(990, 1010);
      pulse(gap);
    end
    rnd_clr = 0;
    repeat (4) pulse(1000);
    repeat (494) step();
    do_reset(4);
    repeat (5) pulse(1000);
    repeat (10) step();
    check("edge_queue_drained", exp_edge.size(), 0);
    check("lost_queue_drained", exp_lost.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pps_period_monitor.md
# pps_period_monitor

Receive-side companion to the PPS-triggered pulse-burst generator. Synchronizes the external PPS input, measures the clock count between successive PPS rising edges and validates it against a nominal period with tolerance. Declares lock after consecutive good periods and flags short, long and missing PPS. Optionally counts the trigger pulses the burst generator emits in each PPS window, so a burst of the wrong length can be detected.

## Interface
Parameters:
- PERIOD_NOM, 100000000: nominal PPS period in i_clk cycles (1 s at 100 MHz).
- PERIOD_TOL, 1000: allowed deviation, ± cycles.
- LOCK_NUM, 3: consecutive valid periods required to lock (≥1).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_pps  in  1  external PPS, asynchronous to i_clk.
- i_trig  in  1  single-cycle trigger pulse, synchronous to i_clk.
- i_clr_err  in  1  clears o_err (synchronous, level).
- o_pps_pulse  out  1  one-cycle strobe per detected PPS rising edge.
- o_period  out  32  last measured period, in cycles.
- o_period_vld  out  1  one-cycle strobe when o_period updates.
- o_trig_count  out  16  trigger pulses counted in the last complete window.
- o_locked  out  1  high while in LOCKED.
- o_err  out  2  sticky flags: bit0 short period, bit1 long period or timeout.
- o_cstate  out  4  current FSM state (debug).

## Operation
- Input sync: i_pps passes through a 2-FF synchronizer and then a delay FF. The internal edge signal is sync2 & ~sync3.
- Period counter (32-bit):
  - Loads 1 on an edge cycle and increments every other cycle.
  - Saturates at 0xFFFFFFFF.
  - At an edge, the measured period P is the counter value before it reloads.
- Window check:
  - short if P < PERIOD_NOM−PERIOD_TOL;
  - long if P > PERIOD_NOM+PERIOD_TOL;
  - otherwise valid. Boundary values are valid.
- States:
  - IDLE (0): first edge → MEASURE. No period is reported, because there is no previous edge.
  - MEASURE (1): on an edge, report P.
    - If P is valid, increment good_cnt; when good_cnt reaches LOCK_NUM, go to LOCKED.
    - If P is invalid, clear good_cnt, set the error bit and stay in MEASURE (this edge restarts the measurement).
  - LOCKED (2): valid edge → stay. Invalid edge → set the error bit, clear good_cnt, go to MEASURE.
  - LOST (3): entered from MEASURE or LOCKED when the counter reaches PERIOD_NOM+PERIOD_TOL+1 with no edge. Sets err[1]. The next edge → MEASURE with good_cnt=0, and no period is reported for that edge.
  - Undefined encodings → IDLE.
- Error flags: sticky. If a set and i_clr_err occur in the same cycle, the set wins.
- Trigger counter (16-bit, saturating):
  - Counts i_trig cycles between edges.
  - At an edge, its value is latched to o_trig_count, including in IDLE and LOST.
  - It then restarts at 1 if i_trig is high that cycle, otherwise at 0.

## Timing
- Reset values: o_pps_pulse=0, o_period=0, o_period_vld=0, o_trig_count=0, o_locked=0, o_err=0, o_cstate=0. Internal counters and good_cnt are 0; synchronizer FFs are 0.
- If i_pps is high at clock edge N, the internal edge occurs in cycle N+1..N+2. At edge N+2, o_pps_pulse, o_period, o_period_vld, o_trig_count, o_err and state all update together.
- o_locked is registered from the next state, so it changes in the same cycle as o_cstate.
- Timeout: LOST and err[1] become visible one cycle after the counter reaches PERIOD_NOM+PERIOD_TOL+1.
- Minimum PPS high or low time: 2 i_clk cycles. Shorter pulses may be missed.
- Reset mid-measurement: all state is discarded and the block returns to IDLE. The first edge after reset only starts a measurement.

## Configuration
- PPS_TRIG_COUNT_EN defined: the trigger counter is built as described.
- Not defined: i_trig is ignored, o_trig_count is tied to 0 and the counter logic is omitted. Period, lock and error behaviour is unchanged.

## Test plan
All scenarios use PERIOD_NOM=1000, PERIOD_TOL=10, LOCK_NUM=3.
- Lock: five PPS edges 1000 cycles apart.
  - o_period=1000 with a strobe on edges 2–5.
  - o_locked rises at edge 4.
  - o_err=0.
- Tolerance boundaries, after lock:
  - periods 990 and 1010 keep lock;
  - a period of 989 sets err[0] and drops lock;
  - a period of 1011 sets err[1].
- Timeout: lock, then stop the PPS.
  - LOST (o_cstate=3) and o_locked=0 at 1011 cycles after the last edge, with err[1]=1.
  - The next edge gives MEASURE with no o_period_vld.
- Trigger count (macro defined): 100 i_trig pulses per window, with one pulse coincident with an edge.
  - o_trig_count=100 each window.
  - The coincident pulse is counted in the new window.
- Sticky clear: assert i_clr_err in the same cycle a short period is detected.
  - err[0]=1 remains.
  - Clear again in an idle cycle → o_err=0.
- Reset mid-window: assert i_rst_n low 500 cycles after an edge while locked.
  - All outputs are at their reset values.
  - The first edge afterwards gives no period.
  - Lock again takes 4 edges.
